// File: rtl/chan_ram_fifo.sv
// chan_ram_fifo: streaming valid/ready FIFO built around a pipelined
// dual-port block RAM (registered write port, 3-edge read-first read port),
// with a 4-entry output skid buffer that hides the read latency so the block
// sustains one word per clock on both sides.
module chan_ram_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tvalid,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tready,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);

  // Control state
  logic [PW-1:0]         wrPtr_q, wrPtr_d;
  logic [PW-1:0]         visPtr_q, visPtr_d;
  logic [PW-1:0]         rdPtr_q, rdPtr_d;
  logic [2:0]            vPipe_q, vPipe_d;
  logic [ADDR_WIDTH-1:0] addrbHold_q, addrbHold_d;
  logic [1:0]            skidWr_q, skidWr_d;
  logic [1:0]            skidRd_q, skidRd_d;
  logic [2:0]            skidCnt_q, skidCnt_d;
  logic [DATA_WIDTH-1:0] skidMem_q [4];

  // Block RAM model state
  logic [DATA_WIDTH-1:0] ramMem_q [DEPTH];
  logic                  ramWea_q;
  logic [ADDR_WIDTH-1:0] ramAddra_q;
  logic [DATA_WIDTH-1:0] ramDia_q;
  logic [ADDR_WIDTH-1:0] ramAddrb_q;
  logic [DATA_WIDTH-1:0] ramRdata_q;
  logic [DATA_WIDTH-1:0] ramDob_q;

  // Combinational datapath/control signals
  logic [PW-1:0]         ramCnt;
  logic [1:0]            inflight;
  logic [3:0]            creditUsed;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  skidPush;
  logic [ADDR_WIDTH-1:0] addrb;

  // Handshakes, occupancy and read-issue decision for the current cycle
  always_comb begin
    ramCnt      = wrPtr_q - rdPtr_q;
    s_tready    = ~reset & (ramCnt < DEPTH_C);
    accept      = s_tvalid & s_tready;
    m_tvalid    = (skidCnt_q != 3'd0);
    m_tdata     = skidMem_q[skidRd_q];
    pop         = m_tvalid & m_tready;
    inflight    = 2'(vPipe_q[0]) + 2'(vPipe_q[1]) + 2'(vPipe_q[2]);
    creditUsed  = 4'(inflight) + 4'(skidCnt_q) - 4'(pop);
    issue       = (visPtr_q != rdPtr_q) & (creditUsed < 4'd4);
    addrb       = issue ? rdPtr_q[ADDR_WIDTH-1:0] : addrbHold_q;
    skidPush    = vPipe_q[2];
    count       = ramCnt + PW'(inflight) + PW'(skidCnt_q);
    almost_full = (count >= AFULL_C);
  end

  // Next-state values for pointers, valid pipe and skid bookkeeping
  always_comb begin
    wrPtr_d     = wrPtr_q + PW'(accept);
    rdPtr_d     = rdPtr_q + PW'(issue);
    visPtr_d    = wrPtr_q;
    vPipe_d     = {vPipe_q[1:0], issue};
    addrbHold_d = addrb;
    skidWr_d    = skidWr_q + 2'(skidPush);
    skidRd_d    = skidRd_q + 2'(pop);
    skidCnt_d   = skidCnt_q + 3'(skidPush) - 3'(pop);
  end

  // Control registers; reset drops every in-flight read and buffered word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      visPtr_q    <= '0;
      rdPtr_q     <= '0;
      vPipe_q     <= '0;
      addrbHold_q <= '0;
      skidWr_q    <= '0;
      skidRd_q    <= '0;
      skidCnt_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      visPtr_q    <= visPtr_d;
      rdPtr_q     <= rdPtr_d;
      vPipe_q     <= vPipe_d;
      addrbHold_q <= addrbHold_d;
      skidWr_q    <= skidWr_d;
      skidRd_q    <= skidRd_d;
      skidCnt_q   <= skidCnt_d;
    end
  end

  // Skid buffer storage: the word leaving the RAM pipe lands at the tail
  always_ff @(posedge clk) begin
    if (skidPush) begin
      skidMem_q[skidWr_q] <= ramDob_q;
    end
  end

  // RAM write port input register: a write commits to the array one edge late
  always_ff @(posedge clk) begin
    ramWea_q   <= accept;
    ramAddra_q <= wrPtr_q[ADDR_WIDTH-1:0];
    ramDia_q   <= s_tdata;
  end

  // RAM array write; the read below samples old contents on the same edge (read-first)
  always_ff @(posedge clk) begin
    if (ramWea_q) begin
      ramMem_q[ramAddra_q] <= ramDia_q;
    end
  end

  // RAM read pipe: address register, array read, output register (3 edges)
  always_ff @(posedge clk) begin
    ramAddrb_q <= addrb;
    ramRdata_q <= ramMem_q[ramAddrb_q];
    ramDob_q   <= ramRdata_q;
  end

  // The credit rule must keep the skid buffer from ever overflowing
  skidNoOverflow: assert property (@(posedge clk) disable iff (reset)
    !(skidPush && !pop && (skidCnt_q == 3'd4)));

endmodule

// File: tb/tb_chan_ram_fifo.sv
// Testbench for chan_ram_fifo: a directed per-cycle vector table, hand-written
// latency/full/reset sequences, and randomized traffic checked against a
// queue-based reference model of the FIFO contents.
module tb_chan_ram_fifo;

  localparam int DEPTH = 256;
  localparam int AFULL = 248;
  localparam int CAP   = DEPTH + 4;

  logic        clk;
  logic        reset;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tready;
  logic [8:0]  count;
  logic        almost_full;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] expQ[$];

  typedef struct packed {
    logic        sValid;
    logic [31:0] sData;
    logic        mReady;
    logic        expSReady;
    logic        expMValid;
    logic [31:0] expMData;
    logic [8:0]  expCount;
  } vecT;

  vecT vecs[16];

  chan_ram_fifo #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .AFULL_THRESH(AFULL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_tvalid(s_tvalid),
    .s_tdata(s_tdata),
    .s_tready(s_tready),
    .m_tvalid(m_tvalid),
    .m_tdata(m_tdata),
    .m_tready(m_tready),
    .count(count),
    .almost_full(almost_full)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the run always ends
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got still running, expected finish before 900000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name, input int budget);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: got timeout, expected completion within %0d cycles", name, budget);
  endtask

  function automatic vecT mk(input logic sv, input logic [31:0] sd, input logic mr,
                             input logic er, input logic ev, input logic [31:0] ed,
                             input logic [8:0] ec);
    vecT v;
    v.sValid    = sv;
    v.sData     = sd;
    v.mReady    = mr;
    v.expSReady = er;
    v.expMValid = ev;
    v.expMData  = ed;
    v.expCount  = ec;
    return v;
  endfunction

  // One clock of traffic against the model; called #1 after an edge
  task automatic stepCycle(output bit acc, output bit popd);
    logic [31:0] expData;
    checkOutput("count vs model", 64'(count), 64'(expQ.size()));
    checkOutput("almost_full vs model", 64'(almost_full), 64'(expQ.size() >= AFULL));
    if (expQ.size() == 0) checkOutput("m_tvalid when empty", 64'(m_tvalid), 64'd0);
    if (expQ.size() < DEPTH) checkOutput("s_tready below depth", 64'(s_tready), 64'd1);
    if (expQ.size() >= CAP) checkOutput("s_tready at capacity", 64'(s_tready), 64'd0);
    acc  = s_tvalid && s_tready;
    popd = m_tvalid && m_tready;
    if (popd && expQ.size() != 0) begin
      expData = expQ.pop_front();
      checkOutput("m_tdata order", 64'(m_tdata), 64'(expData));
    end
    if (acc) expQ.push_back(s_tdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc, pp;
    int sent, got, gaps, drops, cycles, accepted, afAt, pops, lat;

    // Reset and check the idle state
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset s_tready", 64'(s_tready), 64'd0);
    checkOutput("reset m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("reset count", 64'(count), 64'd0);
    checkOutput("reset almost_full", 64'(almost_full), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post-reset s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    // Directed per-cycle vector table
    vecs[0]  = mk(1, 32'hC0DE0000, 0, 1, 0, 32'h0, 9'd1);
    vecs[1]  = mk(1, 32'hC0DE0001, 0, 1, 0, 32'h0, 9'd2);
    vecs[2]  = mk(1, 32'hC0DE0002, 0, 1, 0, 32'h0, 9'd3);
    vecs[3]  = mk(0, 32'h0,        0, 1, 0, 32'h0, 9'd3);
    vecs[4]  = mk(0, 32'h0,        0, 1, 0, 32'h0, 9'd3);
    vecs[5]  = mk(0, 32'h0,        0, 1, 1, 32'hC0DE0000, 9'd3);
    vecs[6]  = mk(0, 32'h0,        0, 1, 1, 32'hC0DE0000, 9'd3);
    vecs[7]  = mk(0, 32'h0,        0, 1, 1, 32'hC0DE0000, 9'd3);
    vecs[8]  = mk(0, 32'h0,        1, 1, 1, 32'hC0DE0001, 9'd2);
    vecs[9]  = mk(1, 32'hC0DE0003, 1, 1, 1, 32'hC0DE0002, 9'd2);
    vecs[10] = mk(0, 32'h0,        1, 1, 0, 32'h0, 9'd1);
    vecs[11] = mk(0, 32'h0,        1, 1, 0, 32'h0, 9'd1);
    vecs[12] = mk(0, 32'h0,        1, 1, 0, 32'h0, 9'd1);
    vecs[13] = mk(0, 32'h0,        1, 1, 0, 32'h0, 9'd1);
    vecs[14] = mk(0, 32'h0,        1, 1, 1, 32'hC0DE0003, 9'd1);
    vecs[15] = mk(0, 32'h0,        1, 1, 0, 32'h0, 9'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].sValid, vecs[i].sData, vecs[i].mReady);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d s_tready", i), 64'(s_tready), 64'(vecs[i].expSReady));
      checkOutput($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].expMValid));
      checkOutput($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d almost_full", i), 64'(almost_full), 64'd0);
      if (vecs[i].expMValid) begin
        checkOutput($sformatf("vec%0d m_tdata", i), 64'(m_tdata), 64'(vecs[i].expMData));
      end
    end

    // Single-word latency: valid after the 5th edge following the accept edge
    applyStimulus(1'b1, 32'hA5A50001, 1'b1);
    checkOutput("latency s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("latency m_tvalid at accept", 64'(m_tvalid), 64'd0);
    checkOutput("latency count held", 64'(count), 64'd1);
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (m_tvalid) lat = n;
    end
    if (lat == 0) reportTimeout("latency m_tvalid", 20);
    else begin
      checkOutput("latency edges", 64'(lat), 64'd5);
      checkOutput("latency m_tdata", 64'(m_tdata), 64'hA5A50001);
      @(posedge clk);
      #1;
      checkOutput("latency drained m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("latency drained count", 64'(count), 64'd0);
    end

    // Continuous 1000-word stream at full rate
    sent = 0; got = 0; gaps = 0; drops = 0; cycles = 0;
    while (got < 1000 && cycles < 3000) begin
      applyStimulus(sent < 1000, 32'h10000000 + 32'(sent), 1'b1);
      if (sent < 1000 && !s_tready) drops++;
      stepCycle(acc, pp);
      if (acc) sent++;
      if (pp) got++;
      else if (got > 0 && got < 1000) gaps++;
      cycles++;
    end
    if (got < 1000) reportTimeout("stream drain", 3000);
    checkOutput("stream s_tready drops", 64'(drops), 64'd0);
    checkOutput("stream output gaps", 64'(gaps), 64'd0);
    checkOutput("stream words accepted", 64'(sent), 64'd1000);

    // Fill with output stalled until s_tready drops
    accepted = 0; cycles = 0; afAt = -1;
    while (s_tready && cycles < 400) begin
      if (almost_full && afAt < 0) afAt = int'(count);
      applyStimulus(1'b1, 32'h20000000 + 32'(accepted), 1'b0);
      stepCycle(acc, pp);
      if (acc) accepted++;
      cycles++;
    end
    if (s_tready) reportTimeout("fill to full", 400);
    checkOutput("full words accepted", 64'(accepted), 64'(CAP));
    checkOutput("full count", 64'(count), 64'(CAP));
    checkOutput("full almost_full", 64'(almost_full), 64'd1);
    checkOutput("almost_full first count", 64'(afAt), 64'(AFULL));
    repeat (3) begin
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
      stepCycle(acc, pp);
    end

    // Pop while full, then a cycle with accept, pop and skid refill together
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle(acc, pp);
    repeat (2) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      stepCycle(acc, pp);
    end
    checkOutput("same-cycle count before", 64'(count), 64'(CAP - 1));
    applyStimulus(1'b1, 32'h30000000, 1'b1);
    checkOutput("same-cycle s_tready", 64'(s_tready), 64'd1);
    checkOutput("same-cycle m_tvalid", 64'(m_tvalid), 64'd1);
    stepCycle(acc, pp);
    checkOutput("same-cycle count after", 64'(count), 64'(CAP - 1));
    cycles = 0;
    while (expQ.size() != 0 && cycles < 400) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      stepCycle(acc, pp);
      cycles++;
    end
    if (expQ.size() != 0) reportTimeout("full drain", 400);

    // Random valid/ready traffic, many pointer wraps
    accepted = 0; cycles = 0;
    while ((accepted < 10000 || expQ.size() != 0) && cycles < 60000) begin
      applyStimulus(accepted < 10000 ? 1'($urandom_range(0, 1)) : 1'b0,
                    $urandom, 1'($urandom_range(0, 1)));
      stepCycle(acc, pp);
      if (acc) accepted++;
      cycles++;
    end
    if (expQ.size() != 0 || accepted < 10000) reportTimeout("random traffic", 60000);

    // Reset with 100 words held and reads in flight
    accepted = 0; cycles = 0;
    while (accepted < 100 && cycles < 300) begin
      applyStimulus(1'b1, 32'h40000000 + 32'(accepted), 1'b0);
      stepCycle(acc, pp);
      if (acc) accepted++;
      cycles++;
    end
    repeat (5) begin
      applyStimulus(1'b1, 32'h50000000 + 32'(accepted), 1'b1);
      stepCycle(acc, pp);
      if (acc) accepted++;
    end
    checkOutput("pre-reset count", 64'(count), 64'd100);
    #2;
    applyStimulus(1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("async reset m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("async reset count", 64'(count), 64'd0);
    checkOutput("async reset s_tready", 64'(s_tready), 64'd0);
    checkOutput("async reset almost_full", 64'(almost_full), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("held reset m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("held reset count", 64'(count), 64'd0);
    end
    reset = 1'b0;
    expQ.delete();
    #1;
    checkOutput("release s_tready", 64'(s_tready), 64'd1);
    repeat (10) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      stepCycle(acc, pp);
    end
    applyStimulus(1'b1, 32'h00001234, 1'b1);
    stepCycle(acc, pp);
    pops = 0; cycles = 0;
    while (cycles < 30) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      stepCycle(acc, pp);
      if (pp) pops++;
      cycles++;
    end
    checkOutput("post-reset words emitted", 64'(pops), 64'd1);
    checkOutput("post-reset final count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
